// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver with single-entry holding register, framing/overrun flags.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky parity_err output.
module uart_rx #(
    parameter int CLKS_PER_BIT = 139,
    parameter int SYNC_STAGES  = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_uart,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    input  logic       err_clr,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_TC = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_TC  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t            state;
    logic [SYNC_STAGES-1:0] sync;
    logic              rxs;
    logic [CW-1:0]     baud_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift;
    logic              baud_tc;

    assign rxs     = sync[SYNC_STAGES-1];
    assign busy    = (state != IDLE);
    assign baud_tc = (baud_cnt == BIT_TC);

    // Synchroniser resets to the idle line level so reset never looks like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx_uart};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            rx_data    <= 8'h00;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
            bit_idx    <= 3'd0;
            baud_cnt   <= '0;
            shift      <= 8'h00;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            // Clears come first so an error event on the same edge wins.
            if (err_clr) begin
                frame_err  <= 1'b0;
                overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
            if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (!rxs) begin
                        state    <= START;
                        baud_cnt <= '0;
                    end
                end
                START: begin
                    if (baud_cnt == HALF_TC) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= rxs ? IDLE : DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        shift    <= {rxs, shift[7:1]};
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        state    <= STOP;
                        if ((^shift) ^ rxs) begin
                            parity_err <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (baud_tc) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        if (!rxs) begin
                            frame_err <= 1'b1;
                        end else if (rx_valid && !rx_ready) begin
                            overrun <= 1'b1;
                        end else begin
                            rx_data  <= shift;
                            rx_valid <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver for the vargen SoC: the receive end of the 8N1 link the SoC transmits on `tx_uart`.
- Samples `rx_uart`, recovers one byte per frame and presents it to the CPU peripheral bus through a single-entry holding register with a valid/ready handshake.
- Flags framing and overrun errors.
- Loopback bench pairs it directly with the SoC transmitter.

Parameters:
- CLKS_PER_BIT, 139, clk cycles per bit period (16 MHz / 115200 baud); must be >= 4.
- SYNC_STAGES, 2, number of flip-flops synchronising `rx_uart` into the clk domain; must be >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous reset, active-high.
- rx_uart  input  1  asynchronous serial line; idles high.
- rx_data  output  8  received byte, valid while rx_valid=1.
- rx_valid  output  1  holding register full.
- rx_ready  input  1  consumer accepts the byte when rx_valid & rx_ready are both high on a clk edge.
- frame_err  output  1  sticky: a stop bit was sampled low.
- overrun  output  1  sticky: a byte completed while the holding register was full.
- err_clr  input  1  clears frame_err and overrun on the next edge.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset:
  - One clock, `clk`.
  - `reset` is synchronous and active-high. It is sampled on the rising edge of `clk` and overrides all other inputs.
  - Reset values: state=IDLE, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0, bit counter=0, baud counter=0, synchroniser flops=1.
- Synchroniser: `rx_uart` passes through SYNC_STAGES flops, giving signal `rxs`. All FSM decisions use `rxs` only.
- Baud counter: width $clog2(CLKS_PER_BIT). Reloads to 0 on every state entry. Counts up to the terminal value given per state, then wraps.
- IDLE:
  - When `rxs`=0, go to START and clear the baud counter.
- START:
  - At baud count = CLKS_PER_BIT/2 - 1 (mid start bit), sample `rxs`.
  - If `rxs`=1, this is a glitch: return to IDLE with no flags set.
  - If `rxs`=0, go to DATA with bit index 0.
- DATA:
  - Every CLKS_PER_BIT cycles, sample `rxs` into shift register bit [index]. Data is LSB first.
  - After index 7 is sampled, go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample `rxs`.
  - If the stop bit is 0: set frame_err. The byte is discarded and rx_valid is unchanged.
  - If the stop bit is 1 and rx_valid=0 (or rx_valid=1 and rx_ready=1 on the same edge): load rx_data and set rx_valid=1.
  - If the stop bit is 1 and rx_valid=1 and rx_ready=0: set overrun. The old rx_data is retained and the new byte is dropped.
  - In all cases return to IDLE.
  - IDLE entered with `rxs` already 0 (back-to-back frames) starts the next frame on the following cycle.
- Handshake:
  - rx_valid & rx_ready on an edge clears rx_valid on that edge, unless a new byte loads on the same edge, in which case rx_valid stays 1.
  - rx_data is stable while rx_valid=1.
- Latency:
  - rx_valid rises on the edge that samples the stop bit.
  - That edge falls 9.5 bit periods + SYNC_STAGES cycles after the start-bit falling edge on `rx_uart`.
- Errors:
  - err_clr clears both sticky flags.
  - If an error event occurs on the same edge as err_clr, the flag ends up set (set wins).
- Reset mid-frame: the partial byte is discarded and the receiver is in IDLE on the next cycle.
- busy = (state != IDLE).

Optional Feature:
- UART_RX_PARITY_EN defined:
  - Frame becomes 8E1: an extra PARITY state sits between DATA and STOP.
  - PARITY samples the parity bit after CLKS_PER_BIT cycles.
  - Adds output `parity_err` (1-bit, sticky, reset 0, cleared by err_clr). It is set when the XOR of the 8 data bits and the parity bit is 1.
  - A byte with a parity error is still loaded, subject to the normal overrun rules.
- UART_RX_PARITY_EN undefined: 8N1 only. The PARITY state and the `parity_err` port do not exist.

Test Plan:
- Reset held for 5 clk, then frame 8'hA5 at 139 clk/bit with rx_ready=0 -> rx_valid=1 and rx_data=8'hA5 about 1320 clk after the start edge; frame_err=0; busy low afterwards.
- Back-to-back frames 8'h00 then 8'hFF, rx_ready pulsed high for one cycle after the first byte -> both bytes received in order; overrun=0.
- Two frames (8'h12, 8'h34) with rx_ready held 0 -> rx_data=8'h12, overrun=1; after err_clr, overrun=0.
- Frame 8'h55 with the stop bit forced low -> frame_err=1, rx_valid stays 0; the next good frame 8'h3C is received normally.
- 40-cycle low glitch on idle `rx_uart` -> return to IDLE, no rx_valid, no flags; then reset asserted mid-frame at bit 4 -> IDLE next cycle, rx_valid=0.
- Loopback with the SoC transmitter, UART_RX_PARITY_EN on, byte 8'h07 sent with parity bit 1 -> parity_err=0; same byte sent with parity bit 0 -> parity_err=1 and rx_data=8'h07.
